// File: rtl/barrel_seq.sv
// Command sequencer for the 8-bit barrel rotator: queues rotate commands,
// issues them one at a time, and returns each rotated result in order.
module barrel_seq #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_load,
  input  logic [2:0]                 cmd_sel,
  input  logic [7:0]                 cmd_data,
  output logic                       bar_load,
  output logic [2:0]                 bar_sel,
  output logic [7:0]                 bar_data,
  input  logic [7:0]                 bar_q,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [7:0]                 res_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [11:0]     fifo_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            bar_load_q, bar_load_d;
  logic [2:0]      bar_sel_q, bar_sel_d;
  logic [7:0]      bar_data_q, bar_data_d;
  logic            res_valid_q, res_valid_d;
  logic [7:0]      res_data_q, res_data_d;
  logic            push_s, pop_s, go_s;
  logic [11:0]     head_s;

  assign cmd_ready = (count_q != CW'(DEPTH));
  assign push_s    = cmd_valid && cmd_ready;
  // Issue only when the result slot is free or is being emptied this edge.
  assign go_s      = (state_q == ST_IDLE) && (count_q != '0) && (!res_valid_q || res_ready);
  assign pop_s     = go_s;
  assign head_s    = fifo_q[rd_ptr_q];

  assign count     = count_q;
  assign bar_load  = bar_load_q;
  assign bar_sel   = bar_sel_q;
  assign bar_data  = bar_data_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= {cmd_load, cmd_sel, cmd_data};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Rotator drive is the hold pattern (0,0,0) except for the single ISSUE cycle.
  always_comb begin
    bar_load_d  = 1'b0;
    bar_sel_d   = 3'd0;
    bar_data_d  = 8'd0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (go_s) begin
      {bar_load_d, bar_sel_d, bar_data_d} = head_s;
    end else begin
      {bar_load_d, bar_sel_d, bar_data_d} = 12'd0;
    end
    case (state_q)
      ST_CAPT: begin
        res_valid_d = 1'b1;
        res_data_d  = bar_q;
      end
      default: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
        end else begin
          res_valid_d = res_valid_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bar_load_q  <= 1'b0;
      bar_sel_q   <= 3'd0;
      bar_data_q  <= 8'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bar_load_q  <= bar_load_d;
      bar_sel_q   <= bar_sel_d;
      bar_data_q  <= bar_data_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

endmodule

// File: tb/tb_barrel_seq.sv
// Scoreboard bench for barrel_seq with a behavioural rotator attached to bar_*.
module tb_barrel_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [2:0] cmd_sel;
  logic [7:0] cmd_data;
  logic       bar_load;
  logic [2:0] bar_sel;
  logic [7:0] bar_data;
  logic [7:0] bar_q;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [2:0] count;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];

  barrel_seq #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .bar_load(bar_load), .bar_sel(bar_sel), .bar_data(bar_data), .bar_q(bar_q),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rotr(input logic [7:0] x, input logic [2:0] s);
    logic [15:0] d;
    d = {x, x} >> s;
    return d[7:0];
  endfunction

  // The rotator itself, reset from the same net inverted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bar_q <= 8'd0;
    else if (bar_load) bar_q <= rotr(bar_data, bar_sel);
    else bar_q <= rotr(bar_q, bar_sel);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (reset === 1'b1 && res_valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got res_valid=%b res_data=%0h expected no result",
                 res_valid, res_data);
      end else begin
        check("res_data", {24'd0, res_data}, {24'd0, exp_q[0]});
        if (res_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic l, input logic [2:0] s, input logic [7:0] d,
                      input logic [7:0] e);
    cmd_valid = 1'b1;
    cmd_load  = l;
    cmd_sel   = s;
    cmd_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
        return;
      end
    end
    n_cmp++;
    n_fail++;
    $display("FAIL push_timeout: got cmd_ready=%b expected 1", cmd_ready);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({nm, "_count"},     {29'd0, count},     32'd0);
    check({nm, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    check({nm, "_res_data"},  {24'd0, res_data},  32'd0);
    check({nm, "_bar"},       {20'd0, bar_load, bar_sel, bar_data}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    res_ready = 1'b1;
    cmd_valid = 1'b0;
    cmd_load  = 1'b0;
    cmd_sel   = 3'd0;
    cmd_data  = 8'd0;

    // Reset held with random command traffic
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'($urandom);
      cmd_load  = 1'($urandom);
      cmd_sel   = 3'($urandom);
      cmd_data  = 8'($urandom);
      @(negedge clk);
      check_reset_outputs("reset");
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Re-rotate right after reset: rotator holds 0
    push(1'b0, 3'd0, 8'hEE, 8'h00);
    wait_drain();

    // Single load with latency and rotator drive checks
    push(1'b1, 3'd3, 8'hB4, 8'h96);
    @(negedge clk);
    check("lat_e0_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    check("lat_e1_valid", {31'd0, res_valid}, 32'd0);
    check("issue_bar", {20'd0, bar_load, bar_sel, bar_data}, {20'd0, 1'b1, 3'd3, 8'hB4});
    @(negedge clk);
    check("lat_e2_valid", {31'd0, res_valid}, 32'd0);
    check("capt_bar", {20'd0, bar_load, bar_sel, bar_data}, 32'd0);
    @(negedge clk);
    check("lat_e3_valid", {31'd0, res_valid}, 32'd1);
    wait_drain();
    repeat (5) @(posedge clk);
    #1;

    // Chained re-rotate
    push(1'b1, 3'd1, 8'h81, 8'hC0);
    push(1'b0, 3'd2, 8'h5A, 8'h30);
    wait_drain();

    // Boundary shift amounts
    push(1'b1, 3'd0, 8'h5A, 8'h5A);
    push(1'b1, 3'd7, 8'h01, 8'h02);
    wait_drain();

    // Back-pressure until the FIFO fills
    res_ready = 1'b0;
    push(1'b1, 3'd4, 8'hF0, 8'h0F);
    push(1'b0, 3'd1, 8'h00, 8'h87);
    push(1'b1, 3'd2, 8'h03, 8'hC0);
    push(1'b0, 3'd4, 8'hFF, 8'h0C);
    push(1'b1, 3'd5, 8'hA5, 8'h2D);
    @(negedge clk);
    check("full_count", {29'd0, count}, 32'd4);
    check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("full_res_valid", {31'd0, res_valid}, 32'd1);
    cmd_valid = 1'b1;
    cmd_load  = 1'b0;
    cmd_sel   = 3'd3;
    cmd_data  = 8'h77;
    repeat (2) @(negedge clk);
    check("full_hold_count", {29'd0, count}, 32'd4);
    check("full_hold_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    push(1'b0, 3'd3, 8'h77, 8'hA5);
    wait_drain();
    @(negedge clk);
    check("drain_count", {29'd0, count}, 32'd0);
    check("drain_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset during CAPT with two commands still queued
    @(posedge clk);
    #1;
    push(1'b1, 3'd1, 8'h11, 8'h88);
    push(1'b1, 3'd2, 8'h44, 8'h11);
    push(1'b0, 3'd1, 8'h00, 8'h88);
    check("precut_count", {29'd0, count}, 32'd2);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_valid", {31'd0, res_valid}, 32'd0);
    check("post_reset_count", {29'd0, count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/barrel_seq.md
# barrel_seq

Command sequencer and result capture wrapped around the 8-bit barrel rotator. It sits directly upstream of the rotator: it accepts rotate commands over a valid/ready interface, buffers them in a small FIFO, and drives the rotator's load, sel and data_in inputs one command at a time. It also consumes the rotator's data_out and presents each rotated result downstream over a second valid/ready interface, strictly in command order.

## Interface
- DEPTH, 4: command FIFO depth; power of two, ≥2.
- clk  in  1  rising-edge clock shared with the rotator.
- reset  in  1  asynchronous, active-low reset; the rotator is reset from the same net, inverted.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; 1 iff count < DEPTH.
- cmd_load  in  1  1: rotate cmd_data; 0: re-rotate the rotator's current contents.
- cmd_sel  in  3  rotate-right amount, 0..7.
- cmd_data  in  8  operand, used when cmd_load=1.
- bar_load  out  1  to rotator load.
- bar_sel  out  3  to rotator sel.
- bar_data  out  8  to rotator data_in.
- bar_q  in  8  from rotator data_out.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  8  rotated result.
- count  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
- Rotator model, per rising edge:
  - load=1: q ← rotr(data_in, sel).
  - load=0: q ← rotr(q, sel).
  - rotr(x,s) = (x>>s)|(x<<(8−s)), 8-bit truncated; s=0 returns x.
  - load=0 with sel=0 holds q, so this is the idle drive.
- FIFO:
  - Push on cmd_valid&cmd_ready.
  - Pop only on the IDLE→ISSUE transition.
  - Push and pop in the same cycle leave count unchanged.
  - Full: cmd_ready=0, no same-cycle pass-through.
  - Pointers wrap modulo DEPTH.
- FSM, all bar_* outputs registered:
  - IDLE: bar_load=0, bar_sel=0, bar_data=0.
    - Go to ISSUE when the FIFO is non-empty and (!res_valid | res_ready).
    - On that edge, pop the head into bar_load/bar_sel/bar_data.
  - ISSUE: bar_* hold the command. The rotator captures at the end of this cycle. Next state is CAPT.
  - CAPT: bar_* return to the hold drive (0,0,0). At the end of the cycle, res_data ← bar_q and res_valid ← 1. Next state is IDLE.
- Result slot:
  - res_valid clears on res_valid&res_ready, unless set in the same edge by CAPT.
  - res_data is stable while res_valid=1 and res_ready=0.
  - Only one command is outstanding, so the slot can never be overwritten.
- cmd_load=0 uses the rotator's last result; after reset that is 0.

## Timing
- Reset values (asynchronous, while reset=0):
  - FSM=IDLE, FIFO empty, count=0, cmd_ready=1.
  - bar_load=0, bar_sel=0, bar_data=0.
  - res_valid=0, res_data=0.
- Reset takes effect immediately at any state. In-flight and queued commands are discarded, and no result appears after release.
- Latency, with an empty FIFO and free slot:
  - Command accepted at edge E0.
  - ISSUE is entered at E1; the rotator updates at E2.
  - res_valid=1 after E3.
- Throughput: one command per 3 cycles.
- Back-pressure:
  - If res_valid=1 and res_ready=0, the FSM stays in IDLE.
  - The FIFO keeps accepting until full.
  - Issue resumes on the edge where res_ready=1 is sampled, concurrent with the slot being emptied.
- cmd_* fields are sampled only on a push edge. Values while cmd_valid=0 are ignored.
- The rotator is only ever driven with hold (0,0) outside ISSUE, so its contents are preserved between commands.

## Test plan
- Reset: hold reset=0 for 3 cycles with random cmd_* → cmd_ready=1, count=0, res_valid=0, bar_*=0 throughout.
- Single load: push {load=1, sel=3, data=8'hB4}, res_ready=1 → res_valid after 3 edges, res_data=8'h96; no further res_valid.
- Chained re-rotate: push {1,1,8'h81} then {0,2,x} → results 8'hC0 then 8'h30, in order.
- Boundaries: {1,0,8'h5A} → 8'h5A; {1,7,8'h01} → 8'h02; {0,0,x} immediately after reset → 8'h00.
- Back-pressure/full, DEPTH=4, res_ready=0: push 6 commands.
  - The first issues and completes; res_valid held with data stable.
  - count reaches 4 and cmd_ready=0, so the 6th waits.
  - Raise res_ready: all 6 results emerge in order, count returns to 0.
- Reset mid-operation: assert reset during CAPT with 2 commands queued → outputs return to reset values immediately; after release no res_valid occurs without new commands.
